// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Data has fixed priority. A starvation counter forces a fetch grant after repeated losses.
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [3:0]            d_be,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic {IDLE, BUSY}   state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  state_t           state, state_d;
  owner_t           owner, owner_d;
  logic             d_we_q, d_we_d;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_d;
  logic             out_en;
  logic             if_win, d_win;

  // out_en holds every output low for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      d_we_q     <= 1'b0;
      starve_cnt <= '0;
      out_en     <= 1'b0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      d_we_q     <= d_we_d;
      starve_cnt <= starve_cnt_d;
      out_en     <= 1'b1;
    end
  end

  // Winner selection, memory mux, grant and response routing.
  always_comb begin
    state_d      = state;
    owner_d      = owner;
    d_we_d       = d_we_q;
    starve_cnt_d = starve_cnt;
    if_win       = 1'b0;
    d_win        = 1'b0;
    if_gnt       = 1'b0;
    if_rvalid    = 1'b0;
    if_rdata     = '0;
    d_gnt        = 1'b0;
    d_rvalid     = 1'b0;
    d_rdata      = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_be       = 4'h0;
    mem_addr     = '0;
    mem_wdata    = '0;

    if (out_en) begin
      unique case (state)
        IDLE: begin
          if_win  = if_req && ((starve_cnt == CNT_MAX) || !d_req);
          d_win   = d_req && !if_win;
          mem_req = if_req | d_req;
          if (d_win) begin
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
          end else if (if_win) begin
            mem_be   = 4'hF;
            mem_addr = if_addr;
          end
          if (mem_req && mem_gnt) begin
            state_d = BUSY;
            if (d_win) begin
              d_gnt   = 1'b1;
              owner_d = OWN_D;
              d_we_d  = d_we;
              if (if_req && (starve_cnt != CNT_MAX)) begin
                starve_cnt_d = starve_cnt + CNT_W'(1);
              end
            end else begin
              if_gnt       = 1'b1;
              owner_d      = OWN_IF;
              starve_cnt_d = '0;
            end
          end
        end
        BUSY: begin
          if (mem_rvalid) begin
            state_d = IDLE;
            if (owner == OWN_IF) begin
              if_rvalid = 1'b1;
              if_rdata  = mem_rdata;
            end else begin
              d_rvalid = 1'b1;
              d_rdata  = d_we_q ? '0 : mem_rdata;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expected values.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    #1;
    // Outputs quiet during reset, even with requests present.
    d_req = 1; if_req = 1; mem_gnt = 1; mem_rvalid = 1;
    sample();
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_gnt", 32'({if_gnt, d_gnt}), 0);
    check("rst_rvalid", 32'({if_rvalid, d_rvalid}), 0);
    tick();
    rst_n = 1;
    sample();
    check("post_rst_mem_req", 32'(mem_req), 0);
    check("post_rst_gnt", 32'({if_gnt, d_gnt}), 0);
    check("post_rst_starve", 32'(dut.starve_cnt), 0);
    tick(); idle_inputs();
    sample();
    check("idle_mem_req", 32'(mem_req), 0);
    check("idle_mem_addr", mem_addr, 0);

    // 1: single load
    tick();
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h100; mem_gnt = 1;
    sample();
    check("ld_d_gnt", 32'(d_gnt), 1);
    check("ld_if_gnt", 32'(if_gnt), 0);
    check("ld_mem_req", 32'(mem_req), 1);
    check("ld_mem_addr", mem_addr, 32'h100);
    check("ld_mem_we", 32'(mem_we), 0);
    tick(); idle_inputs();
    sample();
    check("ld_busy_mem_req", 32'(mem_req), 0);
    check("ld_busy_rvalid", 32'(d_rvalid), 0);
    tick(); mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    sample();
    check("ld_d_rvalid", 32'(d_rvalid), 1);
    check("ld_d_rdata", d_rdata, 32'hDEADBEEF);
    check("ld_if_rvalid", 32'(if_rvalid), 0);
    check("ld_if_rdata", if_rdata, 0);

    // 2: store acknowledge
    tick(); idle_inputs();
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h204; d_wdata = 32'h0000ABCD; mem_gnt = 1;
    sample();
    check("st_d_gnt", 32'(d_gnt), 1);
    check("st_mem_we", 32'(mem_we), 1);
    check("st_mem_be", 32'(mem_be), 32'h3);
    check("st_mem_addr", mem_addr, 32'h204);
    check("st_mem_wdata", mem_wdata, 32'h0000ABCD);
    tick(); idle_inputs(); mem_rvalid = 1; mem_rdata = 32'h12345678;
    sample();
    check("st_d_rvalid", 32'(d_rvalid), 1);
    check("st_d_rdata", d_rdata, 0);

    // 3: priority with starvation limit 4: D,D,D,D,IF,D,D,D,D,IF
    for (int k = 0; k < 10; k++) begin
      logic exp_if;
      exp_if = ((k % 5) == 4);
      tick(); idle_inputs();
      if_req = 1; if_addr = 32'h1000 + 32'(k * 4);
      d_req = 1; d_we = 1; d_be = 4'h5; d_addr = 32'h2000; d_wdata = 32'hA5A5A5A5; mem_gnt = 1;
      sample();
      check($sformatf("sv%0d_if_gnt", k), 32'(if_gnt), 32'(exp_if));
      check($sformatf("sv%0d_d_gnt", k), 32'(d_gnt), 32'(!exp_if));
      if (exp_if) begin
        check($sformatf("sv%0d_if_addr", k), mem_addr, 32'h1000 + 32'(k * 4));
        check($sformatf("sv%0d_if_enc", k), {mem_wdata[27:0], 3'b000, mem_we}, 0);
        check($sformatf("sv%0d_if_be", k), 32'(mem_be), 32'hF);
      end
      tick(); mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'(k + 16);
      sample();
      check($sformatf("sv%0d_busy_gnt", k), 32'({if_gnt, d_gnt}), 0);
      check($sformatf("sv%0d_if_rvalid", k), 32'(if_rvalid), 32'(exp_if));
      check($sformatf("sv%0d_d_rvalid", k), 32'(d_rvalid), 32'(!exp_if));
      if (exp_if) check($sformatf("sv%0d_if_rdata", k), if_rdata, 32'(k + 16));
      else        check($sformatf("sv%0d_d_rdata_st", k), d_rdata, 0);
    end

    // 4: backpressure, D pre-empts a waiting fetch
    for (int c = 0; c < 3; c++) begin
      tick(); idle_inputs();
      if_req = 1; if_addr = 32'h40;
      if (c == 2) begin
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h300;
      end
      sample();
      check($sformatf("bp%0d_gnt", c), 32'({if_gnt, d_gnt}), 0);
      check($sformatf("bp%0d_mem_req", c), 32'(mem_req), 1);
      check($sformatf("bp%0d_mem_addr", c), mem_addr, (c == 2) ? 32'h300 : 32'h40);
    end
    tick(); mem_gnt = 1;
    sample();
    check("bp_d_gnt", 32'(d_gnt), 1);
    check("bp_if_gnt", 32'(if_gnt), 0);
    tick(); d_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0BADF00D;
    sample();
    check("bp_d_rdata", d_rdata, 32'h0BADF00D);
    tick(); mem_rvalid = 0; mem_gnt = 1;
    sample();
    check("bp_if_gnt_late", 32'(if_gnt), 1);
    tick(); idle_inputs(); mem_rvalid = 1; mem_rdata = 32'h77;
    sample();
    check("bp_if_rdata", if_rdata, 32'h77);

    // 5: stray response in IDLE
    tick(); idle_inputs(); mem_rvalid = 1; mem_rdata = 32'hFFFF0000;
    sample();
    check("stray_rvalid", 32'({if_rvalid, d_rvalid}), 0);
    check("stray_rdata", if_rdata | d_rdata, 0);
    tick(); idle_inputs(); d_req = 1; d_addr = 32'h44; mem_gnt = 1;
    sample();
    check("stray_still_idle", 32'(d_gnt), 1);
    tick(); idle_inputs(); mem_rvalid = 1;
    sample();
    check("stray_d_rvalid", 32'(d_rvalid), 1);

    // 6: reset mid-transaction drops the response
    tick(); idle_inputs(); d_req = 1; if_req = 1; mem_gnt = 1;
    sample();
    check("rm_d_gnt", 32'(d_gnt), 1);
    tick(); idle_inputs(); if_req = 1; mem_gnt = 1;
    mem_rvalid = 1; mem_rdata = 32'h1;
    sample();
    check("rm_d_rvalid", 32'(d_rvalid), 1);
    tick(); idle_inputs(); if_req = 1; if_addr = 32'h80; mem_gnt = 1;
    sample();
    check("rm_if_gnt", 32'(if_gnt), 1);
    check("rm_starve_pre", 32'(dut.starve_cnt), 1);
    tick(); idle_inputs(); rst_n = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE;
    sample();
    check("rm_rst_if_rvalid", 32'(if_rvalid), 0);
    tick(); rst_n = 1;
    sample();
    check("rm_post_if_rvalid", 32'(if_rvalid), 0);
    tick();
    sample();
    check("rm_late_if_rvalid", 32'(if_rvalid), 0);
    check("rm_starve", 32'(dut.starve_cnt), 0);
    tick(); idle_inputs(); d_req = 1; d_addr = 32'h500; mem_gnt = 1;
    sample();
    check("rm_d_gnt_after", 32'(d_gnt), 1);
    check("rm_mem_addr", mem_addr, 32'h500);
    tick(); idle_inputs(); mem_rvalid = 1; mem_rdata = 32'h600D;
    sample();
    check("rm_d_rdata", d_rdata, 32'h600D);
    tick(); idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
